qformat_mac: RTL

//  Signed Q-format multiply-accumulate engine: next generation of the Q-format value block.

---
 rtl/qformat_mac.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/qformat_mac.sv
// ----------------------------------------------------------------------------
// qformat_mac
//
// Signed Q-format multiply-accumulate engine. It takes a stream of signed
// Q(I).(F) operand pairs and sums their full-precision Q(2I).(2F) products in
// an accumulator that has G guard bits. When the pair marked last has been
// summed, the total is rescaled back to Q(I).(F), saturated, and held on the
// output until the downstream side accepts it.
//
// Pipeline
//   P : operand product register (prod_q)
//   A : accumulator add; the final sum is captured in sum_q
//   O : rescale/saturate from sum_q into out_value_q
//   The in_last pair is accepted at edge k and out_valid rises after edge k+2.
//
// Handshakes
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. A valid signal stays high, with its payload stable, until that
//   transfer. Ready may rise or fall in any cycle and does not depend on valid
//   in the same cycle.
//
// Optional feature (compile-time macro)
//   QFORMAT_MAC_ROUND_EN : when defined, 2**(F-1) is added before the shift
//                          (round half toward +inf). When undefined, the shift
//                          is a plain arithmetic truncate toward -inf.
//
// Ports
//   clock        in   1  rising-edge clock
//   reset        in   1  synchronous, active-high
//   in_valid     in   1  operand pair valid
//   in_ready     out  1  block can accept an operand pair (ACCUM state, not in reset)
//   in_a         in   W  signed Q operand A
//   in_b         in   W  signed Q operand B
//   in_last      in   1  final pair of the current vector
//   out_valid    out  1  result valid, held until accepted
//   out_ready    in   1  downstream accepts result
//   out_value    out  W  signed Q result, same format as the inputs
//   out_overflow out  1  result saturated, or more than 2**G terms summed
// ----------------------------------------------------------------------------
module qformat_mac #(
    parameter int NUM_FIXED_BITS      = 8,
    parameter int NUM_FRACTIONAL_BITS = 8,
    parameter int ACC_GUARD_BITS      = 4
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0] in_a,
    input  logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0] in_b,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0] out_value,
    output logic                                          out_overflow
);

    localparam int W     = NUM_FIXED_BITS + NUM_FRACTIONAL_BITS;
    localparam int F     = NUM_FRACTIONAL_BITS;
    localparam int G     = ACC_GUARD_BITS;
    localparam int PW    = 2 * W;
    localparam int ACC_W = PW + G;
    localparam int CNT_W = G + 1;

    // The term counter stops at 2**G+1. That value is enough to show that
    // the vector ran past the guard-bit capacity.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(2 ** G);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(2 ** G + 1);

    // Saturation bounds, sign-extended to the rescale width.
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W + 1)'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e                   state_q,     state_d;
    logic signed [PW-1:0]     prod_q,      prod_d;
    logic                     prod_vld_q,  prod_vld_d;
    logic                     prod_last_q, prod_last_d;
    logic signed [ACC_W-1:0]  acc_q,       acc_d;
    logic        [CNT_W-1:0]  cnt_q,       cnt_d;
    logic signed [ACC_W-1:0]  sum_q,       sum_d;
    logic                     sum_vld_q,   sum_vld_d;
    logic                     term_ovf_q,  term_ovf_d;
    logic        [W-1:0]      out_value_q, out_value_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_ovf_q,   out_ovf_d;

    logic                     accept;
    logic signed [PW-1:0]     a_ext;
    logic signed [PW-1:0]     b_ext;
    logic signed [ACC_W-1:0]  prod_sext;
    logic signed [ACC_W-1:0]  sum_now;
    logic        [CNT_W-1:0]  cnt_inc;
    logic signed [ACC_W:0]    sum_ext;
    logic signed [ACC_W:0]    sum_rnd;
    logic signed [ACC_W:0]    shifted;
    logic                     sat_hi;
    logic                     sat_lo;
    logic        [W-1:0]      res_value;

    assign in_ready     = (state_q == ST_ACCUM) && !reset;
    assign accept       = in_valid && in_ready;
    assign out_valid    = out_valid_q;
    assign out_value    = out_value_q;
    assign out_overflow = out_ovf_q;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && in_last)          state_d = ST_FLUSH;
            ST_FLUSH:                                 state_d = ST_HOLD;
            ST_HOLD:  if (out_valid_q && out_ready)   state_d = ST_ACCUM;
            default:                                  state_d = ST_ACCUM;
        endcase
    end

    // ---------------- Stage P: product ----------------
    // The operands are sign-extended to 2W bits first. The product then has
    // full precision, including (-2**(W-1))**2.
    always_comb begin
        a_ext       = {{W{in_a[W-1]}}, in_a};
        b_ext       = {{W{in_b[W-1]}}, in_b};
        prod_vld_d  = accept;
        prod_last_d = accept && in_last;
        // The product register keeps its old value when nothing is accepted.
        // This stops unaccepted operand values from reaching the datapath.
        prod_d      = accept ? (a_ext * b_ext) : prod_q;
    end

    // ---------------- Stage A: accumulate ----------------
    always_comb begin
        prod_sext  = {{G{prod_q[PW-1]}}, prod_q};
        sum_now    = acc_q + prod_sext;
        cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        sum_vld_d  = 1'b0;
        term_ovf_d = term_ovf_q;
        if (prod_vld_q) begin
            if (prod_last_q) begin
                sum_d      = sum_now;
                sum_vld_d  = 1'b1;
                term_ovf_d = (cnt_inc > CNT_LIMIT);
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = sum_now;
                cnt_d = cnt_inc;
            end
        end
    end

    // ---------------- Stage O: rescale + saturate ----------------
    // One spare top bit means the rounding add cannot wrap.
    always_comb begin
        sum_ext = {sum_q[ACC_W-1], sum_q};
`ifdef QFORMAT_MAC_ROUND_EN
        sum_rnd = (F > 0) ? (sum_ext + (ACC_W + 1)'(2 ** ((F > 0) ? F - 1 : 0))) : sum_ext;
`else
        sum_rnd = sum_ext;
`endif
        shifted   = sum_rnd >>> F;
        sat_hi    = (shifted > Q_MAX);
        sat_lo    = (shifted < Q_MIN);
        res_value = sat_hi ? Q_MAX[W-1:0] : (sat_lo ? Q_MIN[W-1:0] : shifted[W-1:0]);
    end

    always_comb begin
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        out_ovf_d   = out_ovf_q;
        if (sum_vld_q) begin
            out_value_d = res_value;
            out_valid_d = 1'b1;
            out_ovf_d   = sat_hi || sat_lo || term_ovf_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_ovf_d   = 1'b0;
        end
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            prod_last_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            sum_vld_q   <= 1'b0;
            term_ovf_q  <= 1'b0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            prod_last_q <= prod_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sum_vld_q   <= sum_vld_d;
            term_ovf_q  <= term_ovf_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
